fmac_seq: RTL and testbench

- Multiply-accumulate sequencer that sits directly upstream of the shared floating-point ALU (opcodes ADD=00, SUB=01, MUL=10, DIV=11).
- Computes a neuron pre-activation: acc = bias + sum over i of (w_i * x_i), all IEEE-754 single precision.
- Drives the ALU opcode and operand ports and registers its combinational result.
- Receives weight/input pairs over a valid/ready stream and emits the final sum with a done pulse.

---
 rtl/falu_pkg.sv | 21 ++
 rtl/fmac_seq.sv | 138 +++++++++++++
 tb/tb_fmac_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/falu_pkg.sv
// Definitions shared by the floating-point ALU and the fmac_seq sequencer:
// ALU opcodes, the sequencer state encoding and common FP constants.
package falu_pkg;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PAIR = 3'd1,
    ST_MUL       = 3'd2,
    ST_ADD       = 3'd3,
    ST_FINISH    = 3'd4
  } fmac_state_e;

endpackage

// File: rtl/fmac_seq.sv
// Multiply-accumulate sequencer: acc = bias + sum(w_i * x_i), with every
// multiply and add carried out by the neighbouring shared FP ALU.
module fmac_seq
  import falu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic [31:0]      bias,
  input  logic             pair_valid,
  output logic             pair_ready,
  input  logic [31:0]      pair_w,
  input  logic [31:0]      pair_x,
  output logic [1:0]       alu_opf,
  output logic [31:0]      alu_regb,
  output logic [31:0]      alu_regc,
  input  logic [31:0]      alu_rega,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output fmac_state_e      dbg_state
);

  // Pair stream handshake: a pair transfers on a rising clk edge where
  // pair_valid && pair_ready. pair_ready is registered and only high in
  // WAIT_PAIR; pair_w/pair_x need only be stable while pair_valid is high.

  fmac_state_e      state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      prod_q, prod_d;
  logic [31:0]      w_q, w_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pair_ready_q, pair_ready_d;
  logic             done_q, done_d;
  logic [1:0]       opf_q, opf_d;
  logic [31:0]      regb_q, regb_d;
  logic [31:0]      regc_q, regc_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    w_d      = w_q;
    x_d      = x_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    opf_d    = opf_q;
    regb_d   = regb_q;
    regc_d   = regc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = bias;
          cnt_d   = n_terms;
          state_d = (n_terms == '0) ? ST_FINISH : ST_WAIT_PAIR;
        end
      end
      ST_WAIT_PAIR: begin
        if (pair_valid && pair_ready_q) begin
          w_d     = pair_w;
          x_d     = pair_x;
          // ALU operands are loaded on the way into MUL so they are stable
          // for the whole MUL cycle.
          opf_d   = MUL;
          regb_d  = pair_w;
          regc_d  = pair_x;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d  = alu_rega;
        opf_d   = ADD;
        regb_d  = acc_q;
        regc_d  = alu_rega;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        acc_d = alu_rega;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        state_d = (cnt_q <= CNT_W'(1)) ? ST_FINISH : ST_WAIT_PAIR;
      end
      ST_FINISH: begin
        result_d = acc_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pair_ready_d = (state_d == ST_WAIT_PAIR);
    done_d       = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= FP_ZERO;
      prod_q       <= FP_ZERO;
      w_q          <= FP_ZERO;
      x_q          <= FP_ZERO;
      result_q     <= FP_ZERO;
      cnt_q        <= '0;
      pair_ready_q <= 1'b0;
      done_q       <= 1'b0;
      opf_q        <= ADD;
      regb_q       <= FP_ZERO;
      regc_q       <= FP_ZERO;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      w_q          <= w_d;
      x_q          <= x_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      pair_ready_q <= pair_ready_d;
      done_q       <= done_d;
      opf_q        <= opf_d;
      regb_q       <= regb_d;
      regc_q       <= regc_d;
    end
  end

  assign pair_ready = pair_ready_q;
  assign done       = done_q;
  assign result     = result_q;
  assign busy       = (state_q != ST_IDLE);
  assign alu_opf    = opf_q;
  assign alu_regb   = regb_q;
  assign alu_regc   = regc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fmac_seq.sv
// Bench for fmac_seq: a behavioural single-precision ALU stands beside the
// DUT; table-driven jobs plus hand-written reset-abort and NaN sequences.
module tb_fmac_seq;
  import falu_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic [31:0]      bias;
  logic             pair_valid;
  logic             pair_ready;
  logic [31:0]      pair_w;
  logic [31:0]      pair_x;
  logic [1:0]       alu_opf;
  logic [31:0]      alu_regb;
  logic [31:0]      alu_regc;
  logic [31:0]      alu_rega;
  logic             busy;
  logic             done;
  logic [31:0]      result;
  fmac_state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0]        bias;
    logic [CNT_W-1:0]   n;
    logic [3:0][31:0]   w;
    logic [3:0][31:0]   x;
    logic [31:0]        exp_res;
    int                 exp_lat;
    int                 stall;
    bit                 noisy;
    bit                 chk_res;
  } vec_t;

  vec_t vecs[8];

  fmac_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_terms(n_terms), .bias(bias),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_w(pair_w),
    .pair_x(pair_x), .alu_opf(alu_opf), .alu_regb(alu_regb),
    .alu_regc(alu_regc), .alu_rega(alu_rega), .busy(busy), .done(done),
    .result(result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural FP ALU ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] dexp;
    if (f[30:23] == 8'h00) return 0.0;
    if (f[30:23] == 8'hFF) return $bitstoreal({f[31], 11'h7FF, 52'b0});
    dexp = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], dexp, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    if (d[62:52] == 11'h7FF)
      return (d[51:0] != 52'b0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'b0};
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'b0);
  endfunction

  function automatic logic [31:0] fp_alu(input logic [1:0] op,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
    if (is_nan(b) || is_nan(c)) return 32'h7FC0_0000;
    case (op)
      ADD:     return r2f(f2r(b) + f2r(c));
      SUB:     return r2f(f2r(b) - f2r(c));
      MUL:     return r2f(f2r(b) * f2r(c));
      default: return r2f(f2r(b) / f2r(c));
    endcase
  endfunction

  always_comb alu_rega = fp_alu(alu_opf, alu_regb, alu_regc);

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a clock edge with the DUT idle.
  task automatic run_job(input string tag, input vec_t v,
                         output logic [31:0] res);
    int  idx = 0;
    int  lat = 0;
    int  ready_cnt = 0;
    int  stall_left = v.stall;
    bit  accept;
    bit  seen_done = 0;
    logic [31:0] exp_p;
    exp_q.delete();
    start      = 1'b1;
    bias       = v.bias;
    n_terms    = v.n;
    pair_valid = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      accept = pair_valid && pair_ready;
      @(posedge clk); #1;
      lat++;
      start = v.noisy ? busy : 1'b0;
      if (accept) begin
        exp_q.push_back(fp_alu(MUL, v.w[idx[1:0]], v.x[idx[1:0]]));
        idx++;
      end
      if (pair_ready) ready_cnt++;
      if (dbg_state == ST_ADD) begin
        exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " prod"}, alu_regc, exp_p);
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      pair_valid = (idx < int'(v.n)) && (stall_left == 0);
      pair_w     = v.w[idx[1:0]];
      pair_x     = v.x[idx[1:0]];
      if (pair_ready && stall_left > 0 && idx == 0) begin
        stall_left--;
        check({tag, " stall busy"}, 32'(busy), 32'd1);
        check({tag, " stall state"}, 32'(dbg_state), 32'(ST_WAIT_PAIR));
      end
    end
    start      = 1'b0;
    pair_valid = 1'b0;
    check({tag, " done seen"}, 32'(seen_done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " ready cycles"}, 32'(ready_cnt), 32'(int'(v.n) + v.stall));
    check({tag, " prods left"}, 32'(exp_q.size()), 32'd0);
    if (v.chk_res) check({tag, " result"}, result, v.exp_res);
    res = result;
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " result hold"}, result, res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] res;
    vec_t        v;

    vecs[0] = '{32'h3F80_0000, 8'd2, {96'h0, 32'h3F00_0000, 32'h4000_0000},
                {96'h0, 32'h4080_0000, 32'h4040_0000}, 32'h4110_0000, 8, 0, 0, 1};
    vecs[1] = '{32'h4040_0000, 8'd0, 128'h0, 128'h0, 32'h4040_0000, 2, 0, 0, 1};
    vecs[2] = '{32'h0000_0000, 8'd1, {96'h0, 32'h4000_0000},
                {96'h0, 32'h4000_0000}, 32'h4080_0000, 5, 0, 0, 1};
    vecs[3] = '{32'h3F80_0000, 8'd3, {32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000},
                {32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000},
                32'h4080_0000, 11, 0, 0, 1};
    vecs[4] = '{32'h0000_0000, 8'd1, {96'h0, 32'hC000_0000},
                {96'h0, 32'h4040_0000}, 32'hC0C0_0000, 5, 0, 0, 1};
    vecs[5] = '{32'h4000_0000, 8'd2, {96'h0, 32'hBF80_0000, 32'h3FC0_0000},
                {96'h0, 32'h3F80_0000, 32'h4000_0000}, 32'h4080_0000, 8, 0, 0, 1};
    vecs[6] = '{32'h0000_0000, 8'd1, {96'h0, 32'h4000_0000},
                {96'h0, 32'h4040_0000}, 32'h40C0_0000, 10, 5, 0, 1};
    vecs[7] = vecs[0];
    vecs[7].noisy = 1;

    reset = 1'b1; start = 1'b0; n_terms = '0; bias = '0;
    pair_valid = 1'b0; pair_w = '0; pair_x = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(pair_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst opf", 32'(alu_opf), 32'(ADD));
    check("rst regb", alu_regb, FP_ZERO);
    check("rst regc", alu_regc, FP_ZERO);
    check("rst result", result, FP_ZERO);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i], res);
    end

    // Reset during the first ADD aborts the job; a fresh job must not see the old acc.
    start = 1'b1; bias = 32'h4120_0000; n_terms = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; pair_valid = 1'b1; pair_w = 32'h4000_0000; pair_x = 32'h4040_0000;
    @(posedge clk); #1;
    pair_valid = 1'b0;
    @(posedge clk); #1;
    check("abort in add", 32'(dbg_state), 32'(ST_ADD));
    reset = 1'b1;
    #1;
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(pair_ready), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort opf", 32'(alu_opf), 32'(ADD));
    check("abort regb", alu_regb, FP_ZERO);
    check("abort regc", alu_regc, FP_ZERO);
    check("abort result", result, FP_ZERO);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort no done", 32'(done), 32'd0);
    v = '{32'h4000_0000, 8'd1, {96'h0, 32'h3F80_0000},
          {96'h0, 32'h4040_0000}, 32'h40A0_0000, 5, 0, 0, 1};
    run_job("fresh", v, res);

    // NaN weight passes through the ALU untouched by the sequencer.
    v = '{FP_ZERO, 8'd1, {96'h0, 32'h7FC0_0000},
          {96'h0, FP_ONE}, 32'h0, 5, 0, 0, 0};
    run_job("nan", v, res);
    check("nan exp", 32'(res[30:23]), 32'hFF);
    check("nan mant nz", 32'(res[22:0] != 23'b0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
